// File: rtl/write_buffer.sv
// Posted-write buffer: CPU writes are queued in a circular FIFO and drained one entry
// at a time, first into the cache and then to SDRAM. Build option WRITE_BUFFER_MERGE_EN folds same-halfword writes.
module write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [15:0] cpu_data,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    output logic        cpu_ack,

    output logic        cache_req,
    output logic [31:0] cache_addr,
    output logic [15:0] cache_data,
    output logic        cache_uds_n,
    output logic        cache_lds_n,
    input  logic        cache_wr_ack,

    output logic        sdram_req,
    output logic [31:0] sdram_addr,
    output logic [15:0] sdram_data,
    output logic        sdram_uds_n,
    output logic        sdram_lds_n,
    input  logic        sdram_ack,

    output logic        empty,
    output logic        full,
    output logic [1:0]  drain_state
);

    // Handshakes: cpu_ack rises on the edge that accepts cpu_req and falls on the first
    // edge that samples cpu_req low. cache_req/sdram_req, with their address, data and
    // byte enables frozen, stay high until the edge that samples the matching ack high.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CACHE = 2'd1,
        SDRAM = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   newest;
    logic [CW-1:0]   count;

    logic [30:0]     mem_addr  [DEPTH];
    logic [15:0]     mem_data  [DEPTH];
    logic            mem_uds_n [DEPTH];
    logic            mem_lds_n [DEPTH];

    logic            merge_hit;
    logic            accept;
    logic            push_new;
    logic            pop;
    logic [30:0]     head_addr;
    logic [15:0]     head_data;
    logic            head_uds_n;
    logic            head_lds_n;
    logic            addr_lsb_unused;

    assign addr_lsb_unused = cpu_addr[0];

    assign newest      = tail - 1'b1;
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0) && (state == IDLE);
    assign drain_state = state;
    assign pop         = (state == SDRAM) && sdram_ack;

`ifdef WRITE_BUFFER_MERGE_EN
    logic [15:0] merged_data;
    logic        merged_uds_n;
    logic        merged_lds_n;
    logic        merge_wr;

    // The head entry is frozen on the output buses once draining starts.
    assign merge_hit = (count != '0)
                    && (mem_addr[newest] == cpu_addr[31:1])
                    && !((newest == head) && (state != IDLE));

    assign merged_data[15:8] = cpu_uds_n ? mem_data[newest][15:8] : cpu_data[15:8];
    assign merged_data[7:0]  = cpu_lds_n ? mem_data[newest][7:0]  : cpu_data[7:0];
    assign merged_uds_n      = mem_uds_n[newest] & cpu_uds_n;
    assign merged_lds_n      = mem_lds_n[newest] & cpu_lds_n;
`else
    assign merge_hit = 1'b0;
`endif

    assign accept   = cpu_req && !cpu_ack && (merge_hit || !full);
    assign push_new = accept && !merge_hit;

`ifdef WRITE_BUFFER_MERGE_EN
    assign merge_wr = accept && merge_hit;
`endif

    // A merge into a lone head entry can coincide with IDLE->CACHE; forward it.
    always_comb begin
        head_addr  = mem_addr[head];
        head_data  = mem_data[head];
        head_uds_n = mem_uds_n[head];
        head_lds_n = mem_lds_n[head];
`ifdef WRITE_BUFFER_MERGE_EN
        if (merge_wr && (newest == head)) begin
            head_data  = merged_data;
            head_uds_n = merged_uds_n;
            head_lds_n = merged_lds_n;
        end
`endif
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_new) begin
            mem_addr[tail]  <= cpu_addr[31:1];
            mem_data[tail]  <= cpu_data;
            mem_uds_n[tail] <= cpu_uds_n;
            mem_lds_n[tail] <= cpu_lds_n;
        end
`ifdef WRITE_BUFFER_MERGE_EN
        else if (merge_wr) begin
            mem_data[newest]  <= merged_data;
            mem_uds_n[newest] <= merged_uds_n;
            mem_lds_n[newest] <= merged_lds_n;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack <= 1'b0;
            count   <= '0;
            head    <= '0;
            tail    <= '0;
        end else begin
            if (accept) begin
                cpu_ack <= 1'b1;
            end else if (!cpu_req) begin
                cpu_ack <= 1'b0;
            end

            if (push_new) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end

            case ({push_new, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cache_req   <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
            cache_uds_n <= 1'b1;
            cache_lds_n <= 1'b1;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            sdram_data  <= '0;
            sdram_uds_n <= 1'b1;
            sdram_lds_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state       <= CACHE;
                        cache_req   <= 1'b1;
                        cache_addr  <= {head_addr, 1'b0};
                        cache_data  <= head_data;
                        cache_uds_n <= head_uds_n;
                        cache_lds_n <= head_lds_n;
                    end
                end
                CACHE: begin
                    if (cache_wr_ack) begin
                        state       <= SDRAM;
                        cache_req   <= 1'b0;
                        sdram_req   <= 1'b1;
                        sdram_addr  <= cache_addr;
                        sdram_data  <= cache_data;
                        sdram_uds_n <= cache_uds_n;
                        sdram_lds_n <= cache_lds_n;
                    end
                end
                SDRAM: begin
                    if (sdram_ack) begin
                        state     <= IDLE;
                        sdram_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cache_req <= 1'b0;
                    sdram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a queue of expected entries is filled as writes are
// accepted and consumed as the cache and SDRAM requests appear.
module tb_write_buffer;

    localparam int W = 50;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_ack;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic [15:0] cache_data;
    logic        cache_uds_n;
    logic        cache_lds_n;
    logic        cache_wr_ack;
    logic        sdram_req;
    logic [31:0] sdram_addr;
    logic [15:0] sdram_data;
    logic        sdram_uds_n;
    logic        sdram_lds_n;
    logic        sdram_ack;
    logic        empty;
    logic        full;
    logic [1:0]  drain_state;

    logic [W-1:0] exp_q[$];
    int test_cnt = 0;
    int fail_cnt = 0;
    int n_push   = 0;

    write_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_ack(cpu_ack),
        .cache_req(cache_req), .cache_addr(cache_addr), .cache_data(cache_data),
        .cache_uds_n(cache_uds_n), .cache_lds_n(cache_lds_n), .cache_wr_ack(cache_wr_ack),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .sdram_uds_n(sdram_uds_n), .sdram_lds_n(sdram_lds_n), .sdram_ack(sdram_ack),
        .empty(empty), .full(full), .drain_state(drain_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pack(input logic [31:0] a, input logic [15:0] d,
                                          input logic u, input logic l);
        return {a, d, u, l};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic write(input logic [31:0] a, input logic [15:0] d,
                         input logic u, input logic l, input bit push_exp);
        cpu_addr  = a;
        cpu_data  = d;
        cpu_uds_n = u;
        cpu_lds_n = l;
        cpu_req   = 1'b1;
        tick();
        check("ack_set", cpu_ack, 1);
        if (push_exp) begin
            exp_q.push_back(pack(a, d, u, l));
            n_push++;
        end
        cpu_req = 1'b0;
        tick();
        check("ack_clear", cpu_ack, 0);
    endtask

    task automatic wait_cache_req(input string tag);
        int n = 0;
        while (!cache_req && n < 50) begin
            tick();
            n++;
        end
        check(tag, cache_req, 1);
    endtask

    // scoreboard: pop one expected entry and compare it on both drain buses
    task automatic drain_one(input string tag);
        logic [W-1:0] e;
        wait_cache_req({tag, "_cache_req"});
        if (exp_q.size() == 0) begin
            test_cnt++;
            fail_cnt++;
            $error("FAIL %s_underflow: observed request expected none", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_cache_entry"}, pack(cache_addr, cache_data, cache_uds_n, cache_lds_n), e);
        cache_wr_ack = 1'b1;
        tick();
        cache_wr_ack = 1'b0;
        check({tag, "_cache_drop"}, cache_req, 0);
        check({tag, "_sdram_req"}, sdram_req, 1);
        check({tag, "_sdram_entry"}, pack(sdram_addr, sdram_data, sdram_uds_n, sdram_lds_n), e);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check({tag, "_sdram_drop"}, sdram_req, 0);
    endtask

    initial begin
        logic [15:0] rd;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
        cache_wr_ack = 1'b0; sdram_ack = 1'b0;
        tick(); tick();
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_reqs", {cache_req, sdram_req}, 0);
        check("rst_empty_full", {empty, full}, 2'b10);
        check("rst_cache_bus", pack(cache_addr, cache_data, cache_uds_n, cache_lds_n), pack(0, 0, 1, 1));
        check("rst_sdram_bus", pack(sdram_addr, sdram_data, sdram_uds_n, sdram_lds_n), pack(0, 0, 1, 1));
        reset = 1'b1;
        tick();

        // single write through both stages
        cpu_addr = 32'h0000_1000; cpu_data = 16'hBEEF; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cpu_req = 1'b1;
        tick();
        check("t1_ack", cpu_ack, 1);
        check("t1_not_empty", empty, 0);
        exp_q.push_back(pack(32'h0000_1000, 16'hBEEF, 0, 0));
        n_push++;
        cpu_req = 1'b0;
        tick();
        check("t1_latency_cache_req", cache_req, 1);
        drain_one("t1");
        check("t1_empty", empty, 1);

        // fill to full, stall the fifth write, then drain in order
        for (int i = 1; i <= 4; i++)
            write(32'h0000_4000 + 32'(i * 2), 16'(i), 1'b0, 1'b0, 1'b1);
        check("t2_full", full, 1);
        cpu_addr = 32'h0000_400A; cpu_data = 16'd5; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cpu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_stall_ack", cpu_ack, 0);
            check("t2_stall_full", full, 1);
        end
        drain_one("t2_e1");
        check("t2_no_push_on_pop_edge", cpu_ack, 0);
        check("t2_space_freed", full, 0);
        tick();
        check("t2_fifth_ack", cpu_ack, 1);
        check("t2_full_again", full, 1);
        exp_q.push_back(pack(32'h0000_400A, 16'd5, 0, 0));
        n_push++;
        cpu_req = 1'b0;
        tick();
        for (int i = 2; i <= 5; i++) drain_one("t2_order");
        check("t2_empty", empty, 1);

        // push coinciding with pop at count 2, then pointer wrap
        write(32'h0000_5000, 16'hA001, 1'b0, 1'b0, 1'b1);
        write(32'h0000_5002, 16'hA002, 1'b0, 1'b0, 1'b1);
        wait_cache_req("t3_cache_req");
        check("t3_cache_entry", pack(cache_addr, cache_data, cache_uds_n, cache_lds_n), exp_q[0]);
        cache_wr_ack = 1'b1;
        tick();
        cache_wr_ack = 1'b0;
        check("t3_sdram_entry", pack(sdram_addr, sdram_data, sdram_uds_n, sdram_lds_n), exp_q[0]);
        void'(exp_q.pop_front());
        cpu_addr = 32'h0000_5004; cpu_data = 16'hA003; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cpu_req = 1'b1; sdram_ack = 1'b1;
        tick();
        check("t3_count_kept", dut.count, 2);
        check("t3_push_ack", cpu_ack, 1);
        check("t3_pop_done", sdram_req, 0);
        exp_q.push_back(pack(32'h0000_5004, 16'hA003, 0, 0));
        n_push++;
        cpu_req = 1'b0; sdram_ack = 1'b0;
        tick();
        write(32'h0000_5006, 16'hA004, 1'b0, 1'b0, 1'b1);
        check("t3_count3", dut.count, 3);
        for (int i = 0; i < 3; i++) drain_one("t3_drain");
        write(32'h0000_5008, 16'hA005, 1'b0, 1'b0, 1'b1);
        write(32'h0000_500A, 16'hA006, 1'b0, 1'b0, 1'b1);
        check("t3_tail_wrap", dut.tail, n_push % 4);
        for (int i = 0; i < 2; i++) drain_one("t3_drain2");
        check("t3_head_wrap", dut.head, n_push % 4);
        check("t3_empty", empty, 1);

        // same-halfword writes queued behind another entry
        write(32'h0000_3000, 16'hAAAA, 1'b0, 1'b0, 1'b1);
        write(32'h0000_2000, 16'h12FF, 1'b0, 1'b1, 1'b0);
        write(32'h0000_2000, 16'hFF34, 1'b1, 1'b0, 1'b0);
`ifdef WRITE_BUFFER_MERGE_EN
        exp_q.push_back(pack(32'h0000_2000, 16'h1234, 0, 0));
        check("t4_merged_count", dut.count, 2);
`else
        exp_q.push_back(pack(32'h0000_2000, 16'h12FF, 0, 1));
        exp_q.push_back(pack(32'h0000_2000, 16'hFF34, 1, 0));
        check("t4_unmerged_count", dut.count, 3);
`endif
        while (exp_q.size() != 0) drain_one("t4_drain");
        check("t4_empty", empty, 1);

        // reset in the middle of an SDRAM write with three entries held
        for (int i = 0; i < 3; i++) begin
            rd = 16'($urandom_range(0, 65535));
            write(32'h0000_6000 + 32'(i * 2), rd, 1'b0, 1'b0, 1'b1);
        end
        wait_cache_req("t5_cache_req");
        cache_wr_ack = 1'b1;
        tick();
        cache_wr_ack = 1'b0;
        check("t5_in_sdram", {sdram_req, drain_state}, {1'b1, 2'd2});
        reset = 1'b0;
        #1;
        check("t5_async_sdram_req", sdram_req, 0);
        check("t5_async_empty", empty, 1);
        check("t5_async_count", dut.count, 0);
        check("t5_async_sdram_bus", pack(sdram_addr, sdram_data, sdram_uds_n, sdram_lds_n), pack(0, 0, 1, 1));
        exp_q.delete();
        n_push = 0;
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_req_after_release", {cache_req, sdram_req, empty}, 3'b001);
        end

        // cpu_req held for six cycles: exactly one push
        rd = 16'($urandom_range(0, 65535));
        cpu_addr = 32'h0000_7000; cpu_data = rd; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_ack_held", cpu_ack, 1);
            check("t6_one_push", dut.count, 1);
        end
        exp_q.push_back(pack(32'h0000_7000, rd, 0, 0));
        cpu_req = 1'b0;
        tick();
        check("t6_ack_cleared", cpu_ack, 0);
        check("t6_count", dut.count, 1);
        drain_one("t6");
        check("t6_empty", empty, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_extra_req", cache_req, 0);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
